bomb_controller: RTL
====================

Name: bomb_controller

Overview:
- Originator of the explosion interface consumed by the box, wall and player logic.
- Latches a bomb at the player's tile on a drop request and runs a fuse timer.
- Emits the explosion location plus a single-cycle explosion enable pulse, holds the blast active for a fixed time, then enforces a cooldown.
- Also tells the pixel mux whether the current VGA pixel lies on the bomb sprite or the plus-shaped blast.

Parameters:
- FUSE_CYCLES, 200000000, clock cycles from drop to detonation.
- BLAST_CYCLES, 50000000, clock cycles the blast stays active.
- COOLDOWN_CYCLES, 25000000, clock cycles after the blast before a new drop is accepted.
- TILE, 16, bomb and blast-arm tile size in pixels; must be a power of two.
- ARM_PX, 48, blast arm reach in pixels beyond the bomb tile, each direction.
- CNT_W, 28, width of the shared phase counter; must hold the largest cycle parameter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- b_x  input  10  bomberman x (top-left pixel)
- b_y  input  10  bomberman y (top-left pixel)
- v_x  input  10  current VGA pixel x
- v_y  input  10  current VGA pixel y
- drop_bomb  input  1  drop request (level, from button sync)
- e_x  output  10  bomb/explosion tile x, top-left
- e_y  output  10  bomb/explosion tile y, top-left
- explosion_SCEN  output  1  one-cycle pulse at detonation
- exploding  output  1  high for the whole blast phase
- bomb_on  output  1  pixel inside the bomb sprite (ARMED only)
- explosion_on  output  1  pixel inside the blast plus (BLAST only)
- busy  output  1  state is not IDLE

Behaviour:
- Reset is synchronous and active-high.
  - Reset values: state IDLE, counter 0, e_x = e_y = 0, explosion_SCEN / exploding / bomb_on / explosion_on / busy = 0.
  - The drop edge register resets to 1, so a button held through reset does not drop a bomb.
  - Reset asserted in any state aborts that state: no pulse is emitted.
- Drop edge: drop_re = drop_bomb & ~drop_q, where drop_q is drop_bomb registered.
- States and transitions:
  - IDLE -> ARMED on drop_re.
    - In the same edge: e_x = min((b_x + TILE/2) & ~(TILE-1), 1024 - TILE); e_y likewise.
    - Use an 11-bit sum so there is no wrap.
    - Counter cleared.
  - ARMED: counter increments each cycle. When counter == FUSE_CYCLES-1 -> BLAST, counter cleared.
  - BLAST:
    - explosion_SCEN = 1 only in the first BLAST cycle (registered; high exactly FUSE_CYCLES cycles after the first ARMED cycle).
    - exploding = 1 throughout.
    - After BLAST_CYCLES cycles -> COOLDOWN.
  - COOLDOWN: after COOLDOWN_CYCLES cycles -> IDLE.
- Drop requests:
  - drop_re outside IDLE is ignored, except as stated under Optional Feature.
  - A held button yields exactly one drop.
  - A new edge is needed after returning to IDLE.
- e_x / e_y are stable from the ARMED entry until the next accepted drop.
- Pixel outputs are registered with 1-cycle latency, matching the box pixel pipeline.
  - bomb_on: state==ARMED and e_x <= v_x <= e_x+TILE-1 and e_y <= v_y <= e_y+TILE-1.
  - explosion_on (state==BLAST) is the union of two bands:
    - horizontal band: v_y in [e_y, e_y+TILE-1] and v_x in [e_x-ARM_PX, e_x+TILE-1+ARM_PX];
    - vertical band: v_x in [e_x, e_x+TILE-1] and v_y in [e_y-ARM_PX, e_y+TILE-1+ARM_PX].
  - All comparisons use 12-bit signed arithmetic. Arms clip at 0 and at 1023 with no wrap-around.
- busy is combinational from state.

Optional Feature:
- REMOTE_DETONATE_EN defined:
  - drop_re while ARMED forces ARMED -> BLAST on the next edge, regardless of the counter.
  - explosion_SCEN pulses as normal and the counter is cleared.
  - A drop_re in the same cycle the fuse expires gives a single transition and a single pulse.
- REMOTE_DETONATE_EN undefined: drop_re in ARMED is ignored.

Test Plan:
- FUSE=10, BLAST=5, COOLDOWN=3; b=(100,37); pulse drop -> e_x=96 (100+8=108 & ~15), e_y=32 (37+8=45 & ~15); explosion_SCEN high exactly 1 cycle, 10 cycles after the first ARMED cycle; exploding high 5 cycles; busy low 3 cycles later.
- Hold drop_bomb high for 40 cycles -> exactly one bomb cycle; no second drop until drop_bomb falls and rises again after IDLE.
- b=(1020,2), ARM_PX=48 -> e_x=1008, e_y=0. During BLAST: pixel (1010,40) on, (1023,8) on, (1000,20) off. Arms clipped with no wrap; no false hit at v_y near 1023.
- BLAST with e=(160,64), sampling 1 cycle after presenting each pixel: (112,64) on, (111,64) off, (160,16) on, (175,127) on, (176,80) off, (159,127) off. In ARMED: bomb_on true for (160..175, 64..79), explosion_on 0.
- Assert reset mid-ARMED and mid-BLAST -> next cycle all outputs 0, state IDLE, no explosion_SCEN afterwards; a drop held through reset produces no bomb.
- With REMOTE_DETONATE_EN: drop, release, drop again at ARMED count 4 -> explosion_SCEN on the next cycle. Without the macro: the second drop is ignored and detonation comes at count 10.

Source files
------------

// File: rtl/bomb_controller_if.sv
// ---------------------------------------------------------------------------
// bomb_controller_if
//
// Purpose:
//   Groups the player position, VGA scan position and drop request, together
//   with everything the bomb controller reports back, into one bundle.
//   The explosion location and enable pulse are consumed by the box, wall and
//   player logic. The sprite hits are consumed by the pixel mux.
//
// Signals:
//   b_x, b_y        [9:0]  bomberman top-left pixel
//   v_x, v_y        [9:0]  current VGA pixel
//   drop_bomb              drop request level (already synchronised)
//   e_x, e_y        [9:0]  bomb / explosion tile top-left
//   explosion_SCEN         one-cycle pulse at detonation
//   exploding              high for the whole blast phase
//   bomb_on                current pixel on the bomb sprite
//   explosion_on           current pixel on the blast plus
//   busy                   controller not idle
//
// Modports:
//   master  game side: drives positions and the drop request
//   slave   the bomb controller itself
// ---------------------------------------------------------------------------
interface bomb_controller_if;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic [9:0] v_x;
  logic [9:0] v_y;
  logic       drop_bomb;
  logic [9:0] e_x;
  logic [9:0] e_y;
  logic       explosion_SCEN;
  logic       exploding;
  logic       bomb_on;
  logic       explosion_on;
  logic       busy;

  modport master (
    output b_x, b_y, v_x, v_y, drop_bomb,
    input  e_x, e_y, explosion_SCEN, exploding, bomb_on, explosion_on, busy
  );

  modport slave (
    input  b_x, b_y, v_x, v_y, drop_bomb,
    output e_x, e_y, explosion_SCEN, exploding, bomb_on, explosion_on, busy
  );
endinterface

// File: rtl/bomb_controller.sv
// ---------------------------------------------------------------------------
// bomb_controller
//
// Purpose:
//   Drops a bomb at the tile nearest the player on a rising drop request and
//   runs a fuse. At detonation it emits a one-cycle explosion pulse and holds
//   the blast active for a fixed time. It then enforces a cooldown before
//   another bomb may be dropped. It also tells the pixel mux, with one cycle
//   of latency, whether the current VGA pixel lies on the bomb sprite or on
//   the plus-shaped blast.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    bomb_controller_if.slave
//          inputs:  b_x, b_y, v_x, v_y, drop_bomb
//          outputs: e_x, e_y, explosion_SCEN, exploding, bomb_on,
//                   explosion_on, busy
//
// Optional feature (macro REMOTE_DETONATE_EN):
//   When defined, a fresh drop request while the bomb is armed detonates it
//   on the next edge, whatever the fuse count. When undefined, such a
//   request is ignored.
// ---------------------------------------------------------------------------
module bomb_controller #(
  parameter int FUSE_CYCLES     = 200000000,
  parameter int BLAST_CYCLES    = 50000000,
  parameter int COOLDOWN_CYCLES = 25000000,
  parameter int TILE            = 16,
  parameter int ARM_PX          = 48,
  parameter int CNT_W           = 28
) (
  input  logic              clk,
  input  logic              reset,
  bomb_controller_if.slave  bus
);

  // Controller phases
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] BLAST    = 2'd2;
  localparam logic [1:0] COOLDOWN = 2'd3;

  // Last counter value of each timed phase. The shared counter starts at 0
  // on phase entry, so a phase of N cycles ends when the counter is N-1.
  localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLAST_LAST = CNT_W'(BLAST_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);

  // Tile snapping constants. The work is 11 bits wide so that b + TILE/2
  // cannot wrap past 1023.
  localparam logic [10:0] SNAP_HALF = 11'(TILE / 2);
  localparam logic [10:0] SNAP_MASK = ~(11'(TILE - 1));
  localparam logic [10:0] SNAP_MAX  = 11'(1024 - TILE);

  // Pixel window constants. The hit tests use 12-bit signed values, so arms
  // reaching past the left or top edge go negative instead of wrapping.
  localparam logic signed [11:0] TILE_M1 = 12'(TILE - 1);
  localparam logic signed [11:0] ARM     = 12'(ARM_PX);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop_q;
  logic [9:0]       r_e_x;
  logic [9:0]       r_e_y;
  logic             r_scen;
  logic             r_bomb_on;
  logic             r_explosion_on;

  logic             w_drop_re;
  logic             w_remote;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_fire;

  logic [10:0]      w_sum_x;
  logic [10:0]      w_sum_y;
  logic [10:0]      w_snap_x;
  logic [10:0]      w_snap_y;
  logic [9:0]       w_tile_x;
  logic [9:0]       w_tile_y;

  logic signed [11:0] w_vx;
  logic signed [11:0] w_vy;
  logic signed [11:0] w_ex;
  logic signed [11:0] w_ey;
  logic               w_in_col;
  logic               w_in_row;
  logic               w_in_arm_x;
  logic               w_in_arm_y;
  logic               w_hit_bomb;
  logic               w_hit_blast;

  // A drop is only the rising edge of the request. The edge register
  // resets high, so a button held through reset looks already seen.
  assign w_drop_re = bus.drop_bomb & ~r_drop_q;

`ifdef REMOTE_DETONATE_EN
  assign w_remote = w_drop_re;
`else
  assign w_remote = 1'b0;
`endif

  // Bomb tile: round the player position to the nearest tile, then clamp
  // so the bomb tile stays fully on screen.
  assign w_sum_x  = {1'b0, bus.b_x} + SNAP_HALF;
  assign w_sum_y  = {1'b0, bus.b_y} + SNAP_HALF;
  assign w_snap_x = w_sum_x & SNAP_MASK;
  assign w_snap_y = w_sum_y & SNAP_MASK;
  assign w_tile_x = (w_snap_x > SNAP_MAX) ? SNAP_MAX[9:0] : w_snap_x[9:0];
  assign w_tile_y = (w_snap_y > SNAP_MAX) ? SNAP_MAX[9:0] : w_snap_y[9:0];

  // Phase sequencing. A single counter times every phase and is cleared on
  // each phase change. In ARMED the fuse expiry and a remote detonation
  // share one branch, so the two together still give one transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_load      = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_drop_re) begin
          w_state_nxt = ARMED;
          w_load      = 1'b1;
        end
      end
      ARMED: begin
        if ((r_cnt == FUSE_LAST) || w_remote) begin
          w_state_nxt = BLAST;
          w_cnt_nxt   = '0;
          w_fire      = 1'b1;
        end
      end
      BLAST: begin
        if (r_cnt == BLAST_LAST) begin
          w_state_nxt = COOLDOWN;
          w_cnt_nxt   = '0;
        end
      end
      COOLDOWN: begin
        if (r_cnt == COOL_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter, latched bomb tile and the detonation pulse. The pulse
  // is registered from the ARMED->BLAST decision, so it is high exactly in
  // the first BLAST cycle. Reset aborts whatever phase is running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_drop_q <= 1'b1;
      r_e_x    <= '0;
      r_e_y    <= '0;
      r_scen   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_drop_q <= bus.drop_bomb;
      r_scen   <= w_fire;
      if (w_load) begin
        r_e_x <= w_tile_x;
        r_e_y <= w_tile_y;
      end
    end
  end

  // Sprite hit tests in signed 12-bit space. The pixel is at most 1023, so
  // an arm extending past the right or bottom edge never matches a wrapped
  // coordinate.
  assign w_vx = signed'({2'b00, bus.v_x});
  assign w_vy = signed'({2'b00, bus.v_y});
  assign w_ex = signed'({2'b00, r_e_x});
  assign w_ey = signed'({2'b00, r_e_y});

  assign w_in_col   = (w_vx >= w_ex) && (w_vx <= w_ex + TILE_M1);
  assign w_in_row   = (w_vy >= w_ey) && (w_vy <= w_ey + TILE_M1);
  assign w_in_arm_x = (w_vx >= w_ex - ARM) && (w_vx <= w_ex + TILE_M1 + ARM);
  assign w_in_arm_y = (w_vy >= w_ey - ARM) && (w_vy <= w_ey + TILE_M1 + ARM);

  assign w_hit_bomb  = w_in_col && w_in_row;
  assign w_hit_blast = (w_in_row && w_in_arm_x) || (w_in_col && w_in_arm_y);

  // Pixel flags are registered so they line up with the one-cycle box
  // pixel pipeline. Each flag is gated by the phase it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bomb_on      <= 1'b0;
      r_explosion_on <= 1'b0;
    end else begin
      r_bomb_on      <= (r_state == ARMED) && w_hit_bomb;
      r_explosion_on <= (r_state == BLAST) && w_hit_blast;
    end
  end

  assign bus.e_x            = r_e_x;
  assign bus.e_y            = r_e_y;
  assign bus.explosion_SCEN = r_scen;
  assign bus.exploding      = (r_state == BLAST);
  assign bus.bomb_on        = r_bomb_on;
  assign bus.explosion_on   = r_explosion_on;
  assign bus.busy           = (r_state != IDLE);

endmodule
